// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared audio datapath constants, FSM encoding and the
//               saturation / coefficient-clamp helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int          SAMPLE_W  = 16;
    localparam logic [15:0] Q15_ONE   = 16'h8000;
    localparam int          Q15_SHIFT = 15;

    // Comb stage FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_DAMP = 2'd1;
    localparam state_t S_FB   = 2'd2;

    // Clamp a wide signed value into the range of a w-bit signed sample
    function automatic logic signed [63:0] sat_sample(input logic signed [63:0] v,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Limit a Q1.15 coefficient to 1.0 so the loop gain can never exceed unity
    function automatic logic [31:0] coef_clamp(input logic [31:0] c);
        return (c > 32'(Q15_ONE)) ? 32'(Q15_ONE) : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/q15_mul.sv
`default_nettype none
// ============================================================================
// Module      : q15_mul
// Description : Signed (WIDTH+1)-bit by unsigned Q1.15 coefficient multiply,
//               rescaled by an arithmetic right shift of 15 (floor rounding).
// Revision    : 1.0 - initial release
// ============================================================================
module q15_mul
    import audio_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int COEF_W = 16
) (
    input  logic signed [WIDTH:0]    i_a,
    input  logic        [COEF_W-1:0] i_c,
    output logic signed [WIDTH:0]    o_p
);

    // A signed (WIDTH+1) operand times an unsigned COEF_W operand fits here
    localparam int PW = WIDTH + COEF_W + 1;

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_c;
    logic signed [PW-1:0] w_prod;

    assign w_a    = PW'(i_a);
    assign w_c    = PW'($signed({1'b0, i_c}));
    assign w_prod = w_a * w_c;

    // With the coefficient limited to 1.0 the rescaled result fits WIDTH+1 bits
    assign o_p = (WIDTH + 1)'(w_prod >>> Q15_SHIFT);

endmodule
`default_nettype wire

// File: rtl/comb_feedback.sv
`default_nettype none
// ============================================================================
// Module      : comb_feedback
// Description : Damped feedback comb stage wrapped around a delay-line FIFO.
//               y = sat(x + g * lp), lp = one-pole low-pass of the delay tap.
//               One shared Q1.15 multiplier serves both the damping and the
//               feedback products, so the stage takes three cycles per sample.
// Revision    : 1.0 - initial release
// ============================================================================
module comb_feedback
    import audio_pkg::*;
#(
    parameter int WIDTH  = SAMPLE_W,
    parameter int COEF_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [WIDTH-1:0]  in_sample,
    input  logic        [COEF_W-1:0] gain,
    input  logic        [COEF_W-1:0] damp,
    input  logic signed [WIDTH-1:0]  fifo_out,
    output logic signed [WIDTH-1:0]  fifo_in,
    output logic                     fifo_enable,
    output logic                     out_valid,
    output logic signed [WIDTH-1:0]  out_sample,
    output logic                     overrun
);

    state_t state_q, state_d;

    logic signed [WIDTH-1:0]  x_q, x_d;
    logic signed [WIDTH-1:0]  d_q, d_d;
    logic signed [WIDTH-1:0]  lp_q, lp_d;
    logic signed [WIDTH-1:0]  lp_nx_q, lp_nx_d;
    logic signed [WIDTH-1:0]  out_sample_q, out_sample_d;
    logic        [COEF_W-1:0] g_q, g_d;
    logic        [COEF_W-1:0] damp_q, damp_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overrun_q, overrun_d;

    logic                     w_accept;
    logic                     w_drop;
    logic signed [WIDTH:0]    w_diff;
    logic signed [WIDTH:0]    w_mul_a;
    logic        [COEF_W-1:0] w_mul_c;
    logic signed [WIDTH:0]    w_mul_p;
    logic signed [WIDTH+1:0]  w_sum;
    logic signed [WIDTH-1:0]  w_y;

    // A new sample is taken only when idle and the FIFO is not shifting this
    // cycle; the tap read during an out_valid cycle would be stale.
    assign w_accept = in_valid && (state_q == S_IDLE) && !out_valid_q;
    assign w_drop   = in_valid && !w_accept;

    // Damping operand: lp - d in WIDTH+1 bits so it cannot overflow
    assign w_diff = {lp_q[WIDTH-1], lp_q} - {d_q[WIDTH-1], d_q};

    // Multiplier is shared: (lp - d) * damp in DAMP, lp_next * g in FB
    assign w_mul_a = (state_q == S_FB) ? {lp_nx_q[WIDTH-1], lp_nx_q} : w_diff;
    assign w_mul_c = (state_q == S_FB) ? g_q : damp_q;

    q15_mul #(
        .WIDTH  (WIDTH),
        .COEF_W (COEF_W)
    ) u_q15_mul (
        .i_a (w_mul_a),
        .i_c (w_mul_c),
        .o_p (w_mul_p)
    );

    // x + fb in WIDTH+2 bits, then clamp to the sample range
    assign w_sum = {{2{x_q[WIDTH-1]}}, x_q} + {w_mul_p[WIDTH], w_mul_p};
    assign w_y   = WIDTH'(sat_sample(64'(w_sum), WIDTH));

    // State and datapath registers; reset aborts any sample in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            d_q          <= '0;
            lp_q         <= '0;
            lp_nx_q      <= '0;
            g_q          <= '0;
            damp_q       <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            d_q          <= d_d;
            lp_q         <= lp_d;
            lp_nx_q      <= lp_nx_d;
            g_q          <= g_d;
            damp_q       <= damp_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state: IDLE -> DAMP -> FB -> IDLE, one pass per accepted sample
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = S_DAMP;
            S_DAMP:  state_d = S_FB;
            S_FB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates and output strobes for each state
    always_comb begin
        x_d          = x_q;
        d_d          = d_q;
        lp_d         = lp_q;
        lp_nx_d      = lp_nx_q;
        g_d          = g_q;
        damp_d       = damp_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        overrun_d    = overrun_q | w_drop;

        if (w_accept) begin
            x_d    = in_sample;
            d_d    = fifo_out;
            g_d    = COEF_W'(coef_clamp(32'(gain)));
            damp_d = COEF_W'(coef_clamp(32'(damp)));
        end

        if (state_q == S_DAMP) begin
            // lp_next = d + (lp - d) * damp; a convex mix, so it fits WIDTH bits
            lp_nx_d = WIDTH'({d_q[WIDTH-1], d_q} + w_mul_p);
        end

        if (state_q == S_FB) begin
            lp_d         = lp_nx_q;
            out_sample_d = w_y;
            out_valid_d  = 1'b1;
        end
    end

    // The FIFO input holds y between updates, so it is stable when sampled
    assign fifo_in     = out_sample_q;
    assign out_sample  = out_sample_q;
    assign fifo_enable = out_valid_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_comb_feedback.sv
`default_nettype none
// ============================================================================
// Module      : tb_comb_feedback
// Description : Directed self-checking bench for comb_feedback with an
//               expected-value queue and a bench-side delay-line FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comb_feedback;

    localparam int LEN = 10;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] in_sample;
    logic        [15:0] gain;
    logic        [15:0] damp;
    logic signed [15:0] fifo_out;
    logic signed [15:0] fifo_in;
    logic               fifo_enable;
    logic               out_valid;
    logic signed [15:0] out_sample;
    logic               overrun;

    logic signed [15:0] fifo_drv;
    logic               loop_en;
    logic signed [15:0] fmem [LEN];
    logic signed [15:0] foreg;

    int total;
    int bad;
    int sb[$];
    int yh[24];

    comb_feedback #(
        .WIDTH  (16),
        .COEF_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_sample   (in_sample),
        .gain        (gain),
        .damp        (damp),
        .fifo_out    (fifo_out),
        .fifo_in     (fifo_in),
        .fifo_enable (fifo_enable),
        .out_valid   (out_valid),
        .out_sample  (out_sample),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay-line FIFO with a registered output tap
    assign fifo_out = loop_en ? foreg : fifo_drv;

    always @(posedge clk) begin
        if (!loop_en) begin
            foreg <= '0;
            for (int i = 0; i < LEN; i++) fmem[i] <= '0;
        end else if (fifo_enable) begin
            foreg <= fmem[LEN-1];
            for (int i = LEN - 1; i > 0; i--) fmem[i] <= fmem[i-1];
            fmem[0] <= fifo_in;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic chk_pop(input string tag);
        int e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_y"}, out_sample, e);
            chk({tag, "_fin"}, fifo_in, e);
        end
    endtask

    // One accepted sample at 4-cycle spacing; pulse expected only in cycle 3
    task automatic run_sample(input string tag, input int x, input int d,
                              input int g, input int dp, input int exp);
        gain      = 16'(g);
        damp      = 16'(dp);
        in_sample = 16'(x);
        fifo_drv  = 16'(d);
        in_valid  = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        chk({tag, "_ov_c0"}, out_valid, 0);
        cyc();
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c < 3) begin
                chk($sformatf("%s_ov_c%0d", tag, c), out_valid, 0);
                chk($sformatf("%s_fe_c%0d", tag, c), fifo_enable, 0);
            end else begin
                chk({tag, "_ov_c3"}, out_valid, 1);
                chk({tag, "_fe_c3"}, fifo_enable, 1);
                chk_pop(tag);
            end
            cyc();
        end
    endtask

    initial begin
        int xv;
        int ev;
        total     = 0;
        bad       = 0;
        loop_en   = 1'b0;
        gain      = '0;
        damp      = '0;
        fifo_drv  = '0;
        in_sample = 16'sd7;
        // in_valid during reset must be ignored
        reset     = 1'b1;
        in_valid  = 1'b1;
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_fifo_in", fifo_in, 0);
        chk("rst_fe", fifo_enable, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_y", out_sample, 0);
        chk("rst_overrun", overrun, 0);
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_overrun", overrun, 0);
        cyc();

        // Passthrough and feedback
        run_sample("pass", 1000, 0, 0, 0, 1000);
        run_sample("fb_pos", 0, 2000, 'h4000, 0, 1000);
        run_sample("fb_neg", -300, -2000, 'h4000, 0, -1300);

        // Saturation at both rails, gain clamped to 1.0
        run_sample("sat_hi", 30000, 30000, 'hFFFF, 0, 32767);
        run_sample("sat_lo", -30000, -30000, 'hFFFF, 0, -32768);
        run_sample("gain_clamp", 0, 1000, 'hFFFF, 0, 1000);
        chk("no_overrun_yet", overrun, 0);

        // Damping state evolves from lp = 0
        do_reset();
        run_sample("damp1", 0, 1000, 'h8000, 'h4000, 500);
        run_sample("damp2", 0, 1000, 'h8000, 'h4000, 750);
        run_sample("damp3", 0, 1000, 'h8000, 'h4000, 875);

        // Overrun: strobes in cycles 0, 2, 3; accept again in cycle 4
        do_reset();
        gain      = '0;
        damp      = '0;
        fifo_drv  = '0;
        in_sample = 16'sd100;
        in_valid  = 1'b1;
        sb.push_back(100);
        @(negedge clk);
        chk("orun_c0", overrun, 0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("orun_c1", overrun, 0);
        cyc();
        in_valid  = 1'b1;
        in_sample = 16'sd555;
        @(negedge clk);
        chk("orun_c2", overrun, 0);
        chk("orun_ov_c2", out_valid, 0);
        cyc();
        in_sample = 16'sd999;
        @(negedge clk);
        chk("orun_ov_c3", out_valid, 1);
        chk("orun_fe_c3", fifo_enable, 1);
        chk("orun_c3", overrun, 1);
        chk_pop("orun_first");
        cyc();
        in_sample = 16'sd200;
        sb.push_back(200);
        @(negedge clk);
        chk("orun_ov_c4", out_valid, 0);
        chk("orun_fe_c4", fifo_enable, 0);
        cyc();
        in_valid = 1'b0;
        for (int c = 5; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("orun_ov_c%0d", c), out_valid, 0);
            chk($sformatf("orun_fe_c%0d", c), fifo_enable, 0);
            cyc();
        end
        @(negedge clk);
        chk("orun_ov_c7", out_valid, 1);
        chk("orun_fe_c7", fifo_enable, 1);
        chk("orun_sticky", overrun, 1);
        chk_pop("orun_second");
        cyc();

        // Reset mid-operation: lp loaded with 5000 first, then aborted sample
        do_reset();
        run_sample("pre_abort", 321, 5000, 0, 0, 321);
        gain      = '0;
        damp      = '0;
        in_sample = 16'sd77;
        in_valid  = 1'b1;
        cyc();
        in_valid = 1'b0;
        reset    = 1'b1;
        cyc();
        reset = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("abort_ov_c%0d", c), out_valid, 0);
            chk($sformatf("abort_fe_c%0d", c), fifo_enable, 0);
            chk($sformatf("abort_y_c%0d", c), out_sample, 0);
            chk($sformatf("abort_fin_c%0d", c), fifo_in, 0);
            chk($sformatf("abort_orun_c%0d", c), overrun, 0);
            cyc();
        end
        // With damp = g = 1.0 and x = 0, y equals the low-pass state
        run_sample("lp_cleared", 0, 123, 'h8000, 'h8000, 0);

        // Closed loop through a LEN-deep FIFO: echoes every LEN+1 samples
        do_reset();
        loop_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            xv = (n == 0) ? 1000 : 0;
            ev = xv;
            if (n >= LEN + 1) ev = xv + (yh[n-LEN-1] >>> 1);
            yh[n] = ev;
            run_sample($sformatf("loop%0d", n), xv, 0, 'h4000, 0, ev);
        end
        loop_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
